// File: rtl/axi4_sram_slave_pkg.sv
// axi4_sram_slave_pkg
// Shared definitions for the AXI4 SRAM responder. It holds the AXI4 bus
// widths, the response and burst codes, the FSM state encoding, and the
// per-beat address helper.
// Optional feature macro: SRAM_RAND_DELAY_EN. It is used by the top module and
// by the delay sub-module, not by this package.
package axi4_sram_slave_pkg;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int STRB_W  = DATA_W / 8;
   localparam int ID_W    = 4;
   localparam int LEN_W   = 8;
   localparam int SIZE_W  = 3;
   localparam int BURST_W = 2;
   localparam int RESP_W  = 2;

   localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
   localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

   localparam logic [BURST_W-1:0] BURST_FIXED = 2'b00;
   localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;
   localparam logic [BURST_W-1:0] BURST_WRAP  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RDELAY = 3'd1,
      ST_RDATA  = 3'd2,
      ST_WDATA  = 3'd3,
      ST_WRESP  = 3'd4
   } state_e;

   // FIXED bursts revisit the start address on every beat. INCR and WRAP both
   // step by one word per beat; this memory never wraps a burst at a boundary.
   function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0]  start,
                                                   input logic [BURST_W-1:0] burst,
                                                   input logic [LEN_W-1:0]   beat);
      if (burst == BURST_FIXED) begin
         return start;
      end
      return start + {22'd0, beat, 2'b00};
   endfunction

endpackage

// File: rtl/axi4_sram_slave_if.sv
// axi4_sram_slave_if
// Groups the five AXI4 channels that connect the load/store master to the SRAM
// responder. The _i and _o suffixes give each signal's direction as seen from
// the slave.
//   slave  modport: used by axi4_sram_slave.
//   master modport: used by the execute stage, the crossbar, or a bench.
interface axi4_sram_slave_if;
   import axi4_sram_slave_pkg::*;

   logic                 awvalid_i;
   logic                 awready_o;
   logic [ADDR_W-1:0]    awaddr_i;
   logic [ID_W-1:0]      awid_i;
   logic [LEN_W-1:0]     awlen_i;
   logic [SIZE_W-1:0]    awsize_i;
   logic [BURST_W-1:0]   awburst_i;

   logic                 wvalid_i;
   logic                 wready_o;
   logic [DATA_W-1:0]    wdata_i;
   logic [STRB_W-1:0]    wstrb_i;
   logic                 wlast_i;

   logic                 bvalid_o;
   logic                 bready_i;
   logic [RESP_W-1:0]    bresp_o;
   logic [ID_W-1:0]      bid_o;

   logic                 arvalid_i;
   logic                 arready_o;
   logic [ADDR_W-1:0]    araddr_i;
   logic [ID_W-1:0]      arid_i;
   logic [LEN_W-1:0]     arlen_i;
   logic [SIZE_W-1:0]    arsize_i;
   logic [BURST_W-1:0]   arburst_i;

   logic                 rvalid_o;
   logic                 rready_i;
   logic [DATA_W-1:0]    rdata_o;
   logic [RESP_W-1:0]    rresp_o;
   logic                 rlast_o;
   logic [ID_W-1:0]      rid_o;

   modport slave (
      input  awvalid_i, awaddr_i, awid_i, awlen_i, awsize_i, awburst_i,
      output awready_o,
      input  wvalid_i, wdata_i, wstrb_i, wlast_i,
      output wready_o,
      output bvalid_o, bresp_o, bid_o,
      input  bready_i,
      input  arvalid_i, araddr_i, arid_i, arlen_i, arsize_i, arburst_i,
      output arready_o,
      output rvalid_o, rdata_o, rresp_o, rlast_o, rid_o,
      input  rready_i
   );

   modport master (
      output awvalid_i, awaddr_i, awid_i, awlen_i, awsize_i, awburst_i,
      input  awready_o,
      output wvalid_i, wdata_i, wstrb_i, wlast_i,
      input  wready_o,
      input  bvalid_o, bresp_o, bid_o,
      output bready_i,
      output arvalid_i, araddr_i, arid_i, arlen_i, arsize_i, arburst_i,
      input  arready_o,
      input  rvalid_o, rdata_o, rresp_o, rlast_o, rid_o,
      output rready_i
   );

endinterface

// File: rtl/axi4_sram_slave_delay_lfsr.sv
// sram_delay_lfsr
// Generates random response delays for the SRAM responder. An 8-bit Fibonacci
// LFSR (taps 8,6,5,4) advances on every cycle, and a small down-counter holds
// the current delay.
// The module exists only when SRAM_RAND_DELAY_EN is defined.
// Ports:
//   clock, reset   system clock; asynchronous, active-low reset
//   load_rd_i      read request accepted: load LFSR[2:0] (0..7 cycles)
//   load_wr_i      last write beat taken: load LFSR[1:0] (0..3 cycles)
//   delay_zero_o   high when no delay cycles remain
`ifdef SRAM_RAND_DELAY_EN
module sram_delay_lfsr #(
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input  logic clock,
   input  logic reset,
   input  logic load_rd_i,
   input  logic load_wr_i,
   output logic delay_zero_o
);

   logic [7:0] lfsr_q, lfsr_d;
   logic [2:0] cnt_q, cnt_d;

   // The LFSR never stops. The counter loads on a request and then counts
   // down to zero, where it stays until the next request.
   always_comb begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      cnt_d  = cnt_q;
      if (load_rd_i) begin
         cnt_d = lfsr_q[2:0];
      end else if (load_wr_i) begin
         cnt_d = {1'b0, lfsr_q[1:0]};
      end else if (cnt_q != 3'd0) begin
         cnt_d = cnt_q - 3'd1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lfsr_q <= LFSR_SEED;
         cnt_q  <= 3'd0;
      end else begin
         lfsr_q <= lfsr_d;
         cnt_q  <= cnt_d;
      end
   end

   assign delay_zero_o = (cnt_q == 3'd0);

endmodule
`endif

// File: rtl/axi4_sram_slave.sv
// axi4_sram_slave
// AXI4 responder backed by an on-chip, word-addressed SRAM. It serves one read
// or write burst at a time and echoes the request ID. Byte strobes select the
// lanes written. Beats outside the address window return SLVERR.
// Ports:
//   clock, reset   system clock; asynchronous, active-low reset
//   bus            AXI4 slave modport (AW, W, B, AR and R channels)
// Parameters: ADDR_BASE (byte address of word 0), DEPTH_WORDS (a power of
// two), LFSR_SEED (seed of the delay LFSR).
// Define SRAM_RAND_DELAY_EN to add random read and write-response delays.
// Without it, each read waits exactly one RDELAY cycle and write responses
// are not delayed.
module axi4_sram_slave
   import axi4_sram_slave_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
   parameter int          DEPTH_WORDS = 4096,
   parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
   input logic              clock,
   input logic              reset,
   axi4_sram_slave_if.slave bus
);

   localparam int          IDX_W        = $clog2(DEPTH_WORDS);
   localparam logic [31:0] WINDOW_BYTES = 32'(4 * DEPTH_WORDS);

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] off;
      off = a - ADDR_BASE;
      return (a >= ADDR_BASE) && (off < WINDOW_BYTES);
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
      return IDX_W'((a - ADDR_BASE) >> 2);
   endfunction

   logic [DATA_W-1:0] mem [DEPTH_WORDS];

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [BURST_W-1:0] burst_q, burst_d;
   logic [LEN_W-1:0]   beat_q, beat_d;
   logic               err_q, err_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;
   logic [RESP_W-1:0]  rresp_q, rresp_d;
   logic               rlast_q, rlast_d;
   logic [RESP_W-1:0]  bresp_q, bresp_d;

   logic               arready, awready, wready, bvalid;
   logic               mem_we, wr_err, load_rd, load_wr, delay_zero;
   logic [LEN_W-1:0]   nxt_beat;
   logic [ADDR_W-1:0]  cur_addr, nxt_addr;
   logic               cur_in_range, nxt_in_range, beat_last;
   logic [DATA_W-1:0]  cur_word, nxt_word;

   assign nxt_beat     = beat_q + 8'd1;
   assign cur_addr     = beat_addr(addr_q, burst_q, beat_q);
   assign nxt_addr     = beat_addr(addr_q, burst_q, nxt_beat);
   assign cur_in_range = in_range(cur_addr);
   assign nxt_in_range = in_range(nxt_addr);
   assign cur_word     = mem[word_idx(cur_addr)];
   assign nxt_word     = mem[word_idx(nxt_addr)];
   assign beat_last    = (beat_q == len_q);
   assign bvalid       = (state_q == ST_WRESP) && delay_zero;

`ifdef SRAM_RAND_DELAY_EN
   sram_delay_lfsr #(.LFSR_SEED(LFSR_SEED)) u_delay (
      .clock        (clock),
      .reset        (reset),
      .load_rd_i    (load_rd),
      .load_wr_i    (load_wr),
      .delay_zero_o (delay_zero)
   );
`else
   assign delay_zero = 1'b1;
   logic unused_delay_cfg;
   assign unused_delay_cfg = ^{LFSR_SEED, load_rd, load_wr};
`endif

   // The transfer size never changes the 4-byte beat step. The strobes alone
   // select which bytes are written.
   logic unused_size;
   assign unused_size = ^{bus.awsize_i, bus.arsize_i};

   // Next-state and datapath logic. Read data is loaded into registers one
   // beat ahead, so R outputs hold steady while the master stalls. A write
   // burst ends on the beat count; a wlast that disagrees only marks the burst
   // as failed.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      id_d    = id_q;
      len_d   = len_q;
      burst_d = burst_q;
      beat_d  = beat_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      rresp_d = rresp_q;
      rlast_d = rlast_q;
      bresp_d = bresp_q;
      arready = 1'b0;
      awready = 1'b0;
      wready  = 1'b0;
      mem_we  = 1'b0;
      wr_err  = err_q;
      load_rd = 1'b0;
      load_wr = 1'b0;
      case (state_q)
         ST_IDLE: begin
            arready = 1'b1;
            awready = !bus.arvalid_i;
            if (bus.arvalid_i) begin
               addr_d  = bus.araddr_i;
               id_d    = bus.arid_i;
               len_d   = bus.arlen_i;
               burst_d = bus.arburst_i;
               beat_d  = '0;
               load_rd = 1'b1;
               state_d = ST_RDELAY;
            end else if (bus.awvalid_i) begin
               addr_d  = bus.awaddr_i;
               id_d    = bus.awid_i;
               len_d   = bus.awlen_i;
               burst_d = bus.awburst_i;
               beat_d  = '0;
               state_d = ST_WDATA;
            end
         end
         ST_RDELAY: begin
            if (delay_zero) begin
               rdata_d = cur_in_range ? cur_word : '0;
               rresp_d = cur_in_range ? RESP_OKAY : RESP_SLVERR;
               rlast_d = beat_last;
               state_d = ST_RDATA;
            end
         end
         ST_RDATA: begin
            if (bus.rready_i) begin
               if (rlast_q) begin
                  rdata_d = '0;
                  rresp_d = RESP_OKAY;
                  rlast_d = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  beat_d  = nxt_beat;
                  rdata_d = nxt_in_range ? nxt_word : '0;
                  rresp_d = nxt_in_range ? RESP_OKAY : RESP_SLVERR;
                  rlast_d = (nxt_beat == len_q);
               end
            end
         end
         ST_WDATA: begin
            wready = 1'b1;
            if (bus.wvalid_i) begin
               if (cur_in_range) begin
                  mem_we = 1'b1;
               end else begin
                  wr_err = 1'b1;
               end
               if (bus.wlast_i != beat_last) begin
                  wr_err = 1'b1;
               end
               err_d = wr_err;
               if (beat_last) begin
                  bresp_d = wr_err ? RESP_SLVERR : RESP_OKAY;
                  load_wr = 1'b1;
                  state_d = ST_WRESP;
               end else begin
                  beat_d = nxt_beat;
               end
            end
         end
         ST_WRESP: begin
            if (bvalid && bus.bready_i) begin
               err_d   = 1'b0;
               bresp_d = RESP_OKAY;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         id_q    <= '0;
         len_q   <= '0;
         burst_q <= '0;
         beat_q  <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
         rlast_q <= 1'b0;
         bresp_q <= RESP_OKAY;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         id_q    <= id_d;
         len_q   <= len_d;
         burst_q <= burst_d;
         beat_q  <= beat_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         rresp_q <= rresp_d;
         rlast_q <= rlast_d;
         bresp_q <= bresp_d;
      end
   end

   // The SRAM array has no reset, so its contents survive a reset. Only the
   // lanes enabled by wstrb are updated.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (bus.wstrb_i[b]) begin
               mem[word_idx(cur_addr)][8*b +: 8] <= bus.wdata_i[8*b +: 8];
            end
         end
      end
   end

   // The ready outputs are held low while reset is asserted. They come up as
   // soon as reset is released.
   assign bus.arready_o = arready & reset;
   assign bus.awready_o = awready & reset;
   assign bus.wready_o  = wready & reset;
   assign bus.rvalid_o  = (state_q == ST_RDATA);
   assign bus.rdata_o   = rdata_q;
   assign bus.rresp_o   = rresp_q;
   assign bus.rlast_o   = rlast_q;
   assign bus.rid_o     = id_q;
   assign bus.bvalid_o  = bvalid;
   assign bus.bresp_o   = bresp_q;
   assign bus.bid_o     = id_q;

endmodule

// File: tb/tb_axi4_sram_slave.sv
// tb_axi4_sram_slave
// Bench for axi4_sram_slave in its default build (SRAM_RAND_DELAY_EN not
// defined). The stimulus tasks first update a word-array model of the memory.
// They then queue the responses the model predicts. A separate monitor pops
// those entries as R and B handshakes occur and compares them.
module tb_axi4_sram_slave;
   import axi4_sram_slave_pkg::*;

   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int          DEPTH = 4096;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
      logic [3:0]  id;
   } rexp_t;

   typedef struct {
      logic [1:0] resp;
      logic [3:0] id;
   } bexp_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   axi4_sram_slave_if bus();

   axi4_sram_slave #(
      .ADDR_BASE   (BASE),
      .DEPTH_WORDS (DEPTH),
      .LFSR_SEED   (8'hA5)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;
   int rdone  = 0;
   int bdone  = 0;
   rexp_t rq[$];
   bexp_t bq[$];
   logic [31:0] ref_mem [DEPTH];
   logic [31:0] wbuf_data [256];
   logic [3:0]  wbuf_strb [256];

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic bit ref_in_range(input logic [31:0] a);
      return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + 4 * DEPTH);
   endfunction

   function automatic logic [31:0] ref_addr(input logic [31:0] start, input logic [1:0] burst, input int beat);
      return (burst == BURST_FIXED) ? start : start + 32'(4 * beat);
   endfunction

   // The monitor pops one expected entry per R or B handshake. It also checks
   // that stalled R outputs hold their value, and that no request is accepted
   // while a response is still pending.
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data;
   logic        prev_last;
   logic [1:0]  prev_resp;
   always @(negedge clock) begin
      if (!reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && bus.rvalid_o) begin
            check_output("r_stable_data", bus.rdata_o, prev_data);
            check_output("r_stable_last", 32'(bus.rlast_o), 32'(prev_last));
            check_output("r_stable_resp", 32'(bus.rresp_o), 32'(prev_resp));
         end
         if (bus.rvalid_o && bus.rready_i) begin
            if (rq.size() == 0) begin
               check_output("r_unexpected", 32'd1, 32'd0);
            end else begin
               rexp_t e;
               e = rq.pop_front();
               check_output("rdata", bus.rdata_o, e.data);
               check_output("rresp", 32'(bus.rresp_o), 32'(e.resp));
               check_output("rlast", 32'(bus.rlast_o), 32'(e.last));
               check_output("rid", 32'(bus.rid_o), 32'(e.id));
            end
            rdone++;
         end
         if (bus.bvalid_o && bus.bready_i) begin
            if (bq.size() == 0) begin
               check_output("b_unexpected", 32'd1, 32'd0);
            end else begin
               bexp_t e;
               e = bq.pop_front();
               check_output("bresp", 32'(bus.bresp_o), 32'(e.resp));
               check_output("bid", 32'(bus.bid_o), 32'(e.id));
            end
            bdone++;
         end
         if (bus.rvalid_o || bus.bvalid_o) begin
            check_output("no_accept_busy", 32'(bus.arready_o | bus.awready_o), 32'd0);
         end
         prev_stall = bus.rvalid_o && !bus.rready_i;
         prev_data  = bus.rdata_o;
         prev_last  = bus.rlast_o;
         prev_resp  = bus.rresp_o;
      end
   end

   // Waits for the given ready (0 = awready, 1 = wready, 2 = arready) and
   // returns just after the clock edge that completes the handshake.
   task automatic wait_hs(input int which, input string name);
      int   n;
      logic r;
      n = 0;
      forever begin
         @(negedge clock);
         case (which)
            0:       r = bus.awready_o;
            1:       r = bus.wready_o;
            default: r = bus.arready_o;
         endcase
         if (r) break;
         n++;
         if (n > 200) begin
            check_output({name, "_timeout"}, 32'd1, 32'd0);
            break;
         end
      end
      @(posedge clock);
      #1;
   endtask

   // Waits, at most 300 cycles, for a monitor count (0 = rdone, 1 = bdone) to
   // reach the target.
   task automatic wait_count(input int which, input int target, input string name);
      int n;
      n = 0;
      do begin
         @(posedge clock);
         #1;
         n++;
      end while ((which == 0 ? rdone : bdone) < target && n < 300);
      if ((which == 0 ? rdone : bdone) < target) begin
         check_output({name, "_timeout"}, 32'd1, 32'd0);
      end
   endtask

   // Predicts a read burst from the model and queues the expected beats.
   task automatic push_read(input logic [31:0] addr, input logic [3:0] id, input int len, input logic [1:0] burst);
      logic [31:0] a;
      for (int b = 0; b <= len; b++) begin
         a = ref_addr(addr, burst, b);
         if (ref_in_range(a)) begin
            rq.push_back('{data: ref_mem[int'((a - BASE) >> 2)], resp: RESP_OKAY, last: (b == len), id: id});
         end else begin
            rq.push_back('{data: 32'd0, resp: RESP_SLVERR, last: (b == len), id: id});
         end
      end
   endtask

   // Applies a write burst to the model and queues the expected B response.
   // wlast_at is the beat that carries wlast (-1 places it on the final beat).
   task automatic push_write(input logic [31:0] addr, input logic [3:0] id, input int len,
                             input logic [1:0] burst, input int wlast_at);
      logic [31:0] a;
      bit          err;
      bit          lst;
      int          idx;
      err = 0;
      for (int b = 0; b <= len; b++) begin
         a   = ref_addr(addr, burst, b);
         lst = (wlast_at < 0) ? (b == len) : (b == wlast_at);
         if (ref_in_range(a)) begin
            idx = int'((a - BASE) >> 2);
            for (int l = 0; l < 4; l++) begin
               if (wbuf_strb[b][l]) ref_mem[idx][8*l +: 8] = wbuf_data[b][8*l +: 8];
            end
         end else begin
            err = 1;
         end
         if (lst != (b == len)) err = 1;
      end
      bq.push_back('{resp: err ? RESP_SLVERR : RESP_OKAY, id: id});
   endtask

   task automatic drive_w_beats(input int len, input int wlast_at);
      for (int b = 0; b <= len; b++) begin
         bus.wvalid_i = 1'b1;
         bus.wdata_i  = wbuf_data[b];
         bus.wstrb_i  = wbuf_strb[b];
         bus.wlast_i  = (wlast_at < 0) ? (b == len) : (b == wlast_at);
         if (b == 0) begin
            @(negedge clock);
            check_output("wready_latency", 32'(bus.wready_o), 32'd1);
            if (bus.wready_o) begin
               @(posedge clock);
               #1;
            end else begin
               wait_hs(1, "wready");
            end
         end else begin
            wait_hs(1, "wready");
         end
      end
      bus.wvalid_i = 1'b0;
      bus.wlast_i  = 1'b0;
   endtask

   task automatic apply_stimulus_write(input logic [31:0] addr, input logic [3:0] id, input int len,
                                       input logic [1:0] burst, input int wlast_at);
      int tgt;
      tgt = bdone + 1;
      push_write(addr, id, len, burst, wlast_at);
      bus.awvalid_i = 1'b1;
      bus.awaddr_i  = addr;
      bus.awid_i    = id;
      bus.awlen_i   = 8'(len);
      bus.awsize_i  = 3'd2;
      bus.awburst_i = burst;
      wait_hs(0, "awready");
      bus.awvalid_i = 1'b0;
      drive_w_beats(len, wlast_at);
      bus.bready_i = 1'b1;
      @(negedge clock);
      check_output("b_latency", 32'(bus.bvalid_o), 32'd1);
      wait_count(1, tgt, "bresp_wait");
      bus.bready_i = 1'b0;
   endtask

   // rmode: 0 = rready held high, 1 = rready toggling, 2 = random rready.
   task automatic apply_stimulus_read(input logic [31:0] addr, input logic [3:0] id, input int len,
                                      input logic [1:0] burst, input int rmode);
      int tgt;
      int n;
      tgt = rdone + len + 1;
      push_read(addr, id, len, burst);
      bus.arvalid_i = 1'b1;
      bus.araddr_i  = addr;
      bus.arid_i    = id;
      bus.arlen_i   = 8'(len);
      bus.arsize_i  = 3'd2;
      bus.arburst_i = burst;
      wait_hs(2, "arready");
      bus.arvalid_i = 1'b0;
      @(negedge clock);
      check_output("rdelay_cycle", 32'(bus.rvalid_o), 32'd0);
      @(negedge clock);
      check_output("r_latency", 32'(bus.rvalid_o), 32'd1);
      n = 0;
      forever begin
         @(posedge clock);
         #1;
         if (rdone >= tgt) break;
         n++;
         if (n > 400) begin
            check_output("rdata_wait_timeout", 32'd1, 32'd0);
            break;
         end
         case (rmode)
            0:       bus.rready_i = 1'b1;
            1:       bus.rready_i = n[0];
            default: bus.rready_i = 1'($urandom_range(0, 1));
         endcase
      end
      bus.rready_i = 1'b0;
   endtask

   task automatic fill_buf(input logic [31:0] base_val, input bit random_data, input logic [3:0] strb);
      for (int i = 0; i < 256; i++) begin
         wbuf_data[i] = random_data ? $urandom : base_val + 32'(i);
         wbuf_strb[i] = strb;
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int tgt;
      int len;
      int sw;
      logic [1:0] burst;
      bus.awvalid_i = 0; bus.awaddr_i = 0; bus.awid_i = 0; bus.awlen_i = 0;
      bus.awsize_i = 0; bus.awburst_i = 0;
      bus.wvalid_i = 0; bus.wdata_i = 0; bus.wstrb_i = 0; bus.wlast_i = 0;
      bus.bready_i = 0;
      bus.arvalid_i = 0; bus.araddr_i = 0; bus.arid_i = 0; bus.arlen_i = 0;
      bus.arsize_i = 0; bus.arburst_i = 0;
      bus.rready_i = 0;

      repeat (3) @(posedge clock);
      @(negedge clock);
      check_output("rst_ready", 32'({bus.arready_o, bus.awready_o, bus.wready_o}), 32'd0);
      check_output("rst_valid", 32'({bus.rvalid_o, bus.bvalid_o, bus.rlast_o}), 32'd0);
      check_output("rst_resp_id", 32'({bus.rresp_o, bus.bresp_o, bus.rid_o, bus.bid_o}), 32'd0);
      check_output("rst_rdata", bus.rdata_o, 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      check_output("post_rst_ready", 32'({bus.arready_o, bus.awready_o}), 32'b11);

      // Fill words 0..127 and the top two words (4094, 4095). The top burst
      // runs past the end of the window, so it returns SLVERR.
      fill_buf(0, 1, 4'hF);
      apply_stimulus_write(BASE, 4'd1, 63, BURST_INCR, -1);
      fill_buf(0, 1, 4'hF);
      apply_stimulus_write(BASE + 32'h100, 4'd2, 63, BURST_INCR, -1);
      fill_buf(0, 1, 4'hF);
      apply_stimulus_write(BASE + 32'h3FF8, 4'd9, 3, BURST_INCR, -1);

      // Single write, then read back.
      wbuf_data[0] = 32'hDEADBEEF; wbuf_strb[0] = 4'hF;
      apply_stimulus_write(32'h8000_0010, 4'd3, 0, BURST_INCR, -1);
      apply_stimulus_read(32'h8000_0010, 4'd3, 0, BURST_INCR, 0);

      // Strobed write: the word should read back as 0xDE22BE44.
      wbuf_data[0] = 32'h11223344; wbuf_strb[0] = 4'b0101;
      apply_stimulus_write(32'h8000_0010, 4'd4, 0, BURST_INCR, -1);
      apply_stimulus_read(32'h8000_0010, 4'd4, 0, BURST_INCR, 0);
      check_output("strobe_model", ref_mem[4], 32'hDE22BE44);

      // INCR burst of 1..4, read back with rready toggling.
      fill_buf(32'd1, 0, 4'hF);
      apply_stimulus_write(32'h8000_0100, 4'd5, 3, BURST_INCR, -1);
      apply_stimulus_read(32'h8000_0100, 4'd5, 3, BURST_INCR, 1);

      // Out-of-range accesses, and an early wlast.
      apply_stimulus_read(32'h7FFF_FFFC, 4'd6, 0, BURST_INCR, 0);
      fill_buf(0, 1, 4'hF);
      apply_stimulus_write(32'h8000_4000, 4'd7, 0, BURST_INCR, -1);
      apply_stimulus_read(BASE, 4'd7, 0, BURST_INCR, 0);
      fill_buf(0, 1, 4'hF);
      apply_stimulus_write(32'h8000_0040, 4'd8, 2, BURST_INCR, 1);
      apply_stimulus_read(32'h8000_0040, 4'd8, 2, BURST_INCR, 2);
      apply_stimulus_read(32'h7FFF_FFF8, 4'd10, 3, BURST_INCR, 2);
      apply_stimulus_read(BASE + 32'h3FF8, 4'd11, 3, BURST_INCR, 0);

      // AR and AW valid together: the read is served first.
      push_read(BASE + 32'h30, 4'd12, 0, BURST_INCR);
      wbuf_data[0] = 32'hCAFE0123; wbuf_strb[0] = 4'hF;
      push_write(BASE + 32'h34, 4'd13, 0, BURST_INCR, -1);
      tgt = rdone + 1;
      bus.arvalid_i = 1; bus.araddr_i = BASE + 32'h30; bus.arid_i = 4'd12;
      bus.arlen_i = 0; bus.arburst_i = BURST_INCR;
      bus.awvalid_i = 1; bus.awaddr_i = BASE + 32'h34; bus.awid_i = 4'd13;
      bus.awlen_i = 0; bus.awburst_i = BURST_INCR;
      @(negedge clock);
      check_output("arb_arready", 32'(bus.arready_o), 32'd1);
      check_output("arb_awready", 32'(bus.awready_o), 32'd0);
      @(posedge clock);
      #1;
      bus.arvalid_i = 0;
      bus.rready_i  = 1;
      wait_count(0, tgt, "arb_read");
      bus.rready_i  = 0;
      wait_hs(0, "arb_awready_late");
      bus.awvalid_i = 0;
      tgt = bdone + 1;
      drive_w_beats(0, -1);
      bus.bready_i = 1;
      wait_count(1, tgt, "arb_bresp");
      bus.bready_i = 0;
      apply_stimulus_read(BASE + 32'h30, 4'd14, 1, BURST_INCR, 0);

      // Reset pulled low while beat 2 of a read burst is presented.
      push_read(BASE + 32'h100, 4'd15, 3, BURST_INCR);
      tgt = rdone + 2;
      bus.arvalid_i = 1; bus.araddr_i = BASE + 32'h100; bus.arid_i = 4'd15;
      bus.arlen_i = 8'd3; bus.arburst_i = BURST_INCR;
      wait_hs(2, "rst_arready");
      bus.arvalid_i = 0;
      bus.rready_i  = 1;
      wait_count(0, tgt, "rst_beats");
      check_output("rst_pre_rvalid", 32'(bus.rvalid_o), 32'd1);
      reset = 1'b0;
      #1;
      check_output("rst_mid_rvalid", 32'(bus.rvalid_o), 32'd0);
      check_output("rst_mid_ready", 32'({bus.arready_o, bus.awready_o}), 32'd0);
      rq.delete();
      bus.rready_i = 0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      check_output("rst_release_arready", 32'(bus.arready_o), 32'd1);
      apply_stimulus_read(BASE + 32'h100, 4'd1, 3, BURST_INCR, 0);

      // Random traffic over words 0..127.
      for (int i = 0; i < 40; i++) begin
         len   = $urandom_range(0, 7);
         burst = 2'($urandom_range(0, 2));
         sw    = $urandom_range(0, 127 - len);
         if ($urandom_range(0, 1) == 1) begin
            for (int b = 0; b < 8; b++) begin
               wbuf_data[b] = $urandom;
               wbuf_strb[b] = 4'($urandom_range(0, 15));
            end
            apply_stimulus_write(BASE + 32'(4 * sw) + 32'($urandom_range(0, 3)),
                                 4'($urandom), len, burst, -1);
         end else begin
            apply_stimulus_read(BASE + 32'(4 * sw) + 32'($urandom_range(0, 3)),
                                4'($urandom), len, burst, 2);
         end
      end

      repeat (3) @(posedge clock);
      check_output("rq_drained", 32'(rq.size()), 32'd0);
      check_output("bq_drained", 32'(bq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
